// File: rtl/uo_pad_pkg.sv
// Shared types and defaults for the uo pad arbiter: FSM state encoding,
// default parameter values, the idle pad constant and counter widths.
package uo_pad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_OWN   = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_IO_WIDTH     = 17;
    localparam int DEF_GUARD_CYCLES = 2;
    localparam int DEF_MAX_HOLD     = 16;

    localparam logic [DEF_IO_WIDTH-1:0] DEF_IDLE_VALUE = '0;

    // Wide enough for GUARD_CYCLES up to 15 and MAX_HOLD up to 255.
    localparam int GUARD_CNT_W = 4;
    localparam int HOLD_CNT_W  = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uo_pad_arbiter_if.sv
// Pad-sharing bus between the requesters and the uo pad arbiter; the
// arbiter sits on the slave side, the requester cluster on the master side.
interface uo_pad_arbiter_if #(
    parameter int NUM_REQ  = uo_pad_pkg::DEF_NUM_REQ,
    parameter int IO_WIDTH = uo_pad_pkg::DEF_IO_WIDTH
) ();

    localparam int ID_W = uo_pad_pkg::id_width(NUM_REQ);

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*IO_WIDTH-1:0] req_data;
    logic [IO_WIDTH-1:0]         ui_p2c;

    logic [NUM_REQ-1:0]          grant;
    logic [ID_W-1:0]             owner_id;
    logic                        busy;
    logic                        preempt;
    logic [IO_WIDTH-1:0]         uo_c2p;
    logic [IO_WIDTH-1:0]         ui_sync;

    modport master (
        output req, req_data, ui_p2c,
        input  grant, owner_id, busy, preempt, uo_c2p, ui_sync
    );

    modport slave (
        input  req, req_data, ui_p2c,
        output grant, owner_id, busy, preempt, uo_c2p, ui_sync
    );

endinterface

// File: rtl/uo_pad_arbiter_rr_pick.sv
// Combinational round-robin search: first requester found starting at
// (last + 1) mod NUM_REQ and wrapping around to last itself.
module rr_pick
    import uo_pad_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    logic [ID_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((32'(last) + i) % 32'(NUM_REQ));
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uo_pad_arbiter.sv
// Arbitrates NUM_REQ requesters onto a shared set of uo output pads with a
// guard gap before every handover, hold-time preemption and a ui synchronizer.
module uo_pad_arbiter
    import uo_pad_pkg::*;
#(
    parameter int                  NUM_REQ      = DEF_NUM_REQ,
    parameter int                  IO_WIDTH     = DEF_IO_WIDTH,
    parameter int                  GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int                  MAX_HOLD     = DEF_MAX_HOLD,
    parameter logic [IO_WIDTH-1:0] IDLE_VALUE   = IO_WIDTH'(DEF_IDLE_VALUE)
) (
    input logic             io_clock,
    input logic             io_reset_n,
    uo_pad_arbiter_if.slave bus
);

    localparam int ID_W = id_width(NUM_REQ);

    localparam logic [GUARD_CNT_W-1:0] GUARD_LOAD = GUARD_CNT_W'(GUARD_CYCLES - 1);
    localparam logic [HOLD_CNT_W-1:0]  HOLD_SAT   = HOLD_CNT_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]        LAST_ID    = ID_W'(NUM_REQ - 1);

    arb_state_e             state_q;
    logic [ID_W-1:0]        owner_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic                   busy_q;
    logic                   preempt_q;
    logic [IO_WIDTH-1:0]    uo_q;
    logic [GUARD_CNT_W-1:0] guard_cnt_q;
    logic [HOLD_CNT_W-1:0]  hold_cnt_q;
    logic [IO_WIDTH-1:0]    ui_meta_q;
    logic [IO_WIDTH-1:0]    ui_sync_q;

    logic [ID_W-1:0]        pick_id;
    logic                   pick_valid;
    logic [NUM_REQ-1:0]     owner_mask;
    logic                   owner_req;
    logic                   competitor;
    logic                   hold_sat;
    logic [IO_WIDTH-1:0]    data_arr [NUM_REQ];
    logic [IO_WIDTH-1:0]    owner_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (bus.req),
        .last   (owner_q),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign data_arr[g] = bus.req_data[g*IO_WIDTH +: IO_WIDTH];
    end

    always_comb begin
        owner_mask = NUM_REQ'(1) << owner_q;
        owner_req  = |(bus.req & owner_mask);
        competitor = |(bus.req & ~owner_mask);
        hold_sat   = (hold_cnt_q == HOLD_SAT);
        owner_data = data_arr[owner_q];
    end

    // owner_q is latched at selection time, so an abandoned request still
    // advances the round-robin pointer past that requester.
    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= LAST_ID;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            preempt_q   <= 1'b0;
            uo_q        <= IDLE_VALUE;
            guard_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    grant_q <= '0;
                    uo_q    <= IDLE_VALUE;
                    busy_q  <= pick_valid;
                    if (pick_valid) begin
                        owner_q     <= pick_id;
                        guard_cnt_q <= GUARD_LOAD;
                        state_q     <= ST_GUARD;
                    end
                end

                ST_GUARD: begin
                    grant_q <= '0;
                    uo_q    <= IDLE_VALUE;
                    if (!owner_req) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (guard_cnt_q == '0) begin
                        grant_q    <= owner_mask;
                        hold_cnt_q <= '0;
                        state_q    <= ST_OWN;
                    end else begin
                        guard_cnt_q <= guard_cnt_q - 1'b1;
                    end
                end

                ST_OWN: begin
                    // A release in the same cycle as saturation wins over preemption.
                    if (!owner_req || (hold_sat && competitor)) begin
                        grant_q   <= '0;
                        uo_q      <= IDLE_VALUE;
                        busy_q    <= 1'b0;
                        preempt_q <= owner_req;
                        state_q   <= ST_IDLE;
                    end else begin
                        uo_q <= owner_data;
                        if (!hold_sat) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    grant_q <= '0;
                    uo_q    <= IDLE_VALUE;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            ui_meta_q <= '0;
            ui_sync_q <= '0;
        end else begin
            ui_meta_q <= bus.ui_p2c;
            ui_sync_q <= ui_meta_q;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.owner_id = owner_q;
    assign bus.busy     = busy_q;
    assign bus.preempt  = preempt_q;
    assign bus.uo_c2p   = uo_q;
    assign bus.ui_sync  = ui_sync_q;

endmodule

// File: tb/tb_uo_pad_arbiter.sv
// Directed self-checking bench for uo_pad_arbiter at default parameters:
// guard timing, round-robin order, preemption, abandonment, reset and ui sync.
module tb_uo_pad_arbiter;

    logic io_clock   = 1'b0;
    logic io_reset_n = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [16:0] D0 = 17'h1A5A5;
    localparam logic [16:0] D1 = 17'h11111;
    localparam logic [16:0] D2 = 17'h12222;
    localparam logic [16:0] D3 = 17'h13333;

    uo_pad_arbiter_if #(.NUM_REQ(4), .IO_WIDTH(17)) bus ();

    uo_pad_arbiter #(
        .NUM_REQ      (4),
        .IO_WIDTH     (17),
        .GUARD_CYCLES (2),
        .MAX_HOLD     (16),
        .IDLE_VALUE   (17'h00000)
    ) dut (
        .io_clock   (io_clock),
        .io_reset_n (io_reset_n),
        .bus        (bus)
    );

    always #5 io_clock = ~io_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge io_clock);
        #1;
    endtask

    task automatic do_reset();
        io_reset_n = 1'b0;
        tick();
        io_reset_n = 1'b1;
    endtask

    logic [3:0]  exp_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  exp_owner [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    int unsigned gap;
    int unsigned hold;
    int unsigned bad;
    logic [3:0]  g;

    initial begin
        bus.req      = 4'b0000;
        bus.req_data = {D3, D2, D1, D0};
        bus.ui_p2c   = 17'h1FFFF;

        // Reset state, held across edges.
        tick();
        tick();
        check_eq("rst_grant",   32'(bus.grant),    32'h0);
        check_eq("rst_owner",   32'(bus.owner_id), 32'h3);
        check_eq("rst_busy",    32'(bus.busy),     32'h0);
        check_eq("rst_preempt", 32'(bus.preempt),  32'h0);
        check_eq("rst_uo",      32'(bus.uo_c2p),   32'h0);
        check_eq("rst_ui_sync", 32'(bus.ui_sync),  32'h0);

        // ui synchronizer latency while IDLE.
        io_reset_n = 1'b1;
        bus.ui_p2c = 17'h00F0F;
        tick();
        check_eq("sync_idle_e1", 32'(bus.ui_sync), 32'h0);
        tick();
        check_eq("sync_idle_e2", 32'(bus.ui_sync), 32'h00F0F);

        // Single requester from reset release: 1 IDLE + 2 GUARD edges.
        bus.req = 4'b0001;
        do_reset();
        tick();
        check_eq("a_e1_grant", 32'(bus.grant),  32'h0);
        check_eq("a_e1_busy",  32'(bus.busy),   32'h1);
        check_eq("a_e1_uo",    32'(bus.uo_c2p), 32'h0);
        tick();
        check_eq("a_e2_grant", 32'(bus.grant),  32'h0);
        tick();
        check_eq("a_e3_grant", 32'(bus.grant),    32'b0001);
        check_eq("a_e3_uo",    32'(bus.uo_c2p),   32'h0);
        check_eq("a_e3_owner", 32'(bus.owner_id), 32'h0);
        tick();
        check_eq("a_e4_uo",    32'(bus.uo_c2p),   32'h1A5A5);
        bus.req_data = {D3, D2, D1, 17'h05555};
        tick();
        check_eq("a_e5_uo",    32'(bus.uo_c2p),   32'h05555);
        bus.req = 4'b0000;
        tick();
        check_eq("a_rel_grant",   32'(bus.grant),   32'h0);
        check_eq("a_rel_uo",      32'(bus.uo_c2p),  32'h0);
        check_eq("a_rel_busy",    32'(bus.busy),    32'h0);
        check_eq("a_rel_preempt", 32'(bus.preempt), 32'h0);
        bus.req_data = {D3, D2, D1, D0};

        // All four requesting: 0,1,2,3,0, 16 cycles each, preempt between.
        bus.req = 4'b1111;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            gap = 0;
            while (bus.grant == 4'b0000 && gap < 10) begin
                tick();
                gap++;
            end
            check_eq($sformatf("rr%0d_gap", k),     gap,              32'd3);
            check_eq($sformatf("rr%0d_grant", k),   32'(bus.grant),   32'(exp_grant[k]));
            check_eq($sformatf("rr%0d_owner", k),   32'(bus.owner_id), 32'(exp_owner[k]));
            check_eq($sformatf("rr%0d_pre_lo", k),  32'(bus.preempt), 32'h0);
            g = bus.grant;
            hold = 0;
            while (bus.grant == g && hold < 40) begin
                tick();
                hold++;
            end
            check_eq($sformatf("rr%0d_hold", k),    hold,             32'd16);
            check_eq($sformatf("rr%0d_pre_hi", k),  32'(bus.preempt), 32'h1);
            check_eq($sformatf("rr%0d_off", k),     32'(bus.grant),   32'h0);
        end

        // Lone requester keeps the pads past MAX_HOLD.
        bus.req = 4'b0100;
        gap = 0;
        while (bus.grant == 4'b0000 && gap < 10) begin
            tick();
            gap++;
        end
        check_eq("solo_gap",   gap,            32'd3);
        check_eq("solo_grant", 32'(bus.grant), 32'b0100);
        bus.ui_p2c = 17'h00000;
        tick();
        check_eq("sync_own_e1", 32'(bus.ui_sync), 32'h00F0F);
        tick();
        check_eq("sync_own_e2", 32'(bus.ui_sync), 32'h0);
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (bus.grant != 4'b0100 || bus.preempt != 1'b0) bad++;
        end
        check_eq("solo_bad",   bad,             32'd0);
        check_eq("solo_uo",    32'(bus.uo_c2p), 32'h12222);

        // req[1] abandoned in its second GUARD cycle, req[3] then served.
        bus.req    = 4'b1010;
        io_reset_n = 1'b0;
        tick();
        check_eq("ab_rst_owner", 32'(bus.owner_id), 32'h3);
        io_reset_n = 1'b1;
        tick();
        check_eq("ab_e1_owner", 32'(bus.owner_id), 32'h1);
        tick();
        bus.req = 4'b1000;
        tick();
        check_eq("ab_e3_grant", 32'(bus.grant), 32'h0);
        check_eq("ab_e3_busy",  32'(bus.busy),  32'h0);
        tick();
        check_eq("ab_e4_grant", 32'(bus.grant),    32'h0);
        check_eq("ab_e4_busy",  32'(bus.busy),     32'h1);
        check_eq("ab_e4_owner", 32'(bus.owner_id), 32'h3);
        tick();
        check_eq("ab_e5_grant", 32'(bus.grant), 32'h0);
        tick();
        check_eq("ab_e6_grant", 32'(bus.grant), 32'b1000);

        // Asynchronous reset mid-OWN, then lowest index wins first.
        tick();
        check_eq("rs_uo_own", 32'(bus.uo_c2p), 32'h13333);
        #2;
        io_reset_n = 1'b0;
        #1;
        check_eq("rs_grant", 32'(bus.grant),    32'h0);
        check_eq("rs_uo",    32'(bus.uo_c2p),   32'h0);
        check_eq("rs_owner", 32'(bus.owner_id), 32'h3);
        check_eq("rs_busy",  32'(bus.busy),     32'h0);
        bus.req = 4'b0110;
        tick();
        check_eq("rs_held_grant", 32'(bus.grant), 32'h0);
        io_reset_n = 1'b1;
        bus.ui_p2c = 17'h00F0F;
        tick();
        check_eq("rs_e1_grant",   32'(bus.grant),   32'h0);
        check_eq("rs_e1_busy",    32'(bus.busy),    32'h1);
        check_eq("sync_guard_e1", 32'(bus.ui_sync), 32'h0);
        tick();
        check_eq("rs_e2_grant",   32'(bus.grant),   32'h0);
        check_eq("sync_guard_e2", 32'(bus.ui_sync), 32'h00F0F);
        tick();
        check_eq("rs_e3_grant", 32'(bus.grant),    32'b0010);
        check_eq("rs_e3_owner", 32'(bus.owner_id), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
